mem_access_stage: RTL

- Memory-access (M) stage. It consumes the registered X→M bundle through a valid/ready handshake.
- For loads and stores it performs one AXI4-Lite master transaction, then formats load data.
- It presents the result to the W-stage register with a valid/ready handshake.
- Non-memory instructions pass through in a fixed 1-cycle hop.

---
 rtl/mem_access_stage.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory-access stage: one AXI4-Lite read or write per load/store, load-data formatting, W handshake.
// Optional MISALIGN_CHECK_EN faults misaligned half/word accesses without touching the bus.
module mem_access_stage #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              mvalid,
  input  logic              mwen,
  input  logic [7:0]        mwmask,
  input  logic [2:0]        mrtype,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       memdata,
  output logic              fault,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWreq, StWresp, StDone} state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_mwmask;
  logic [2:0]          r_mrtype;
  logic [31:0]         r_wdata_in;
  logic                r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready, r_m_valid, r_fault;
  logic [31:0]         r_memdata;

  logic                w_xfer;
  logic                w_misalign;
  logic                w_unused_mask;
  logic [31:0]         w_rshift;
  logic [31:0]         w_ldata;
  logic                w_aw_done, w_w_done;

  assign w_xfer        = s_valid && (r_state == StIdle);
  assign w_unused_mask = ^mwmask[7:4];

`ifdef MISALIGN_CHECK_EN
  logic w_half, w_word;
  always_comb begin
    w_half = 1'b0;
    w_word = 1'b0;
    if (mwen) begin
      w_half = (mwmask[3:0] == 4'h3);
      w_word = (mwmask[3:0] == 4'hF);
    end else begin
      w_half = (mrtype == 3'd1) || (mrtype == 3'd5);
      w_word = !((mrtype == 3'd0) || (mrtype == 3'd4) || w_half);
    end
  end
  assign w_misalign = mvalid && ((w_half && addr[0]) || (w_word && (addr[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  // Load data is taken from the word shifted down by the byte offset, then extended.
  assign w_rshift = rdata >> {r_addr[1:0], 3'b000};
  always_comb begin
    w_ldata = w_rshift;
    case (r_mrtype)
      3'd0:    w_ldata = {{24{w_rshift[7]}}, w_rshift[7:0]};
      3'd1:    w_ldata = {{16{w_rshift[15]}}, w_rshift[15:0]};
      3'd4:    w_ldata = {24'd0, w_rshift[7:0]};
      3'd5:    w_ldata = {16'd0, w_rshift[15:0]};
      default: w_ldata = w_rshift;
    endcase
  end

  assign w_aw_done = !r_awvalid || awready;
  assign w_w_done  = !r_wvalid || wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_mwmask   <= '0;
      r_mrtype   <= '0;
      r_wdata_in <= '0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_m_valid  <= 1'b0;
      r_fault    <= 1'b0;
      r_memdata  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_xfer) begin
            r_addr     <= addr;
            r_mwmask   <= mwmask[3:0];
            r_mrtype   <= mrtype;
            r_wdata_in <= wdata_in;
            r_memdata  <= '0;
            r_fault    <= 1'b0;
            if (!mvalid || w_misalign) begin
              r_state   <= StDone;
              r_m_valid <= 1'b1;
              r_fault   <= w_misalign;
            end else if (mwen) begin
              r_state   <= StWreq;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= StRaddr;
              r_arvalid <= 1'b1;
            end
          end
        end
        StRaddr: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StRdata;
          end
        end
        StRdata: begin
          if (rvalid) begin
            r_rready  <= 1'b0;
            r_memdata <= w_ldata;
            r_fault   <= (rresp != 2'b00);
            r_m_valid <= 1'b1;
            r_state   <= StDone;
          end
        end
        StWreq: begin
          // The two channels complete independently; move on once both have.
          if (awready) r_awvalid <= 1'b0;
          if (wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= StWresp;
          end
        end
        StWresp: begin
          if (bvalid) begin
            r_bready  <= 1'b0;
            r_memdata <= '0;
            r_fault   <= (bresp != 2'b00);
            r_m_valid <= 1'b1;
            r_state   <= StDone;
          end
        end
        StDone: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign s_ready = (r_state == StIdle);
  assign m_valid = r_m_valid;
  assign memdata = r_memdata;
  assign fault   = r_fault;
  assign araddr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign arvalid = r_arvalid;
  assign rready  = r_rready;
  assign awaddr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign awvalid = r_awvalid;
  assign wdata   = r_wdata_in << {r_addr[1:0], 3'b000};
  assign wstrb   = r_mwmask << r_addr[1:0];
  assign wvalid  = r_wvalid;
  assign bready  = r_bready;

endmodule
